// File: rtl/gray_frame_ctrl.sv
// Frame sequencer for the grayscale stage: pulls one IMG_W x IMG_H RGB frame from the
// pixel source, feeds the gray filter and writes results to the frame buffer in raster order.
module gray_frame_ctrl #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int PX_BW   = 32,
    parameter int GRAY_BW = 8,
    parameter int ADDR_BW = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [PX_BW-1:0]   i_src_px,
    input  logic               i_src_valid,
    output logic               o_src_ready,
    output logic [PX_BW-1:0]   o_gf_px,
    output logic               o_gf_valid,
    input  logic [GRAY_BW-1:0] i_gf_px,
    input  logic               i_gf_valid,
    output logic               o_wr_en,
    output logic [ADDR_BW-1:0] o_wr_addr,
    output logic [GRAY_BW-1:0] o_wr_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int CNT_BW = ADDR_BW + 1;
    localparam logic [CNT_BW-1:0] N_CNT    = CNT_BW'(IMG_W * IMG_H);
    localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(IMG_W * IMG_H - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_BW-1:0] iss_cnt, iss_cnt_nx;
    logic [CNT_BW-1:0] wr_cnt, wr_cnt_nx;
    logic              active, hs, wr_ok, start_ok, err_set;

    always_comb begin
        active      = (state == STREAM) || (state == DRAIN);
        o_src_ready = (state == STREAM) && (iss_cnt != N_CNT);
        o_busy      = active;
        o_done      = (state == DONE);
        // abort masks handshake and write so neither advances its counter
        hs          = i_src_valid && o_src_ready && !i_abort;
        wr_ok       = active && i_gf_valid && (wr_cnt != N_CNT) && !i_abort;
        start_ok    = (state == IDLE) && i_start && !i_abort;
        err_set     = i_gf_valid && (!active || (wr_cnt == N_CNT));

        state_nx   = state;
        iss_cnt_nx = iss_cnt;
        wr_cnt_nx  = wr_cnt;
        if (hs)    iss_cnt_nx = iss_cnt + 1'b1;
        if (wr_ok) wr_cnt_nx  = wr_cnt + 1'b1;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx   = STREAM;
                    iss_cnt_nx = '0;
                    wr_cnt_nx  = '0;
                end
            end
            STREAM: begin
                if (wr_cnt == N_CNT)
                    state_nx = DONE;
                else if (hs && (iss_cnt == LAST_CNT))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (wr_cnt == N_CNT)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (i_abort) begin
            state_nx   = IDLE;
            iss_cnt_nx = '0;
            wr_cnt_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            iss_cnt    <= '0;
            wr_cnt     <= '0;
            o_gf_px    <= '0;
            o_gf_valid <= 1'b0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nx;
            iss_cnt    <= iss_cnt_nx;
            wr_cnt     <= wr_cnt_nx;
            o_gf_valid <= hs;
            if (hs)
                o_gf_px <= i_src_px;
            o_wr_en <= wr_ok;
            if (wr_ok) begin
                o_wr_addr <= wr_cnt[ADDR_BW-1:0];
                o_wr_data <= i_gf_px;
            end
            // a stray filter result in the same cycle as a start still flags
            o_err <= (start_ok ? 1'b0 : o_err) | err_set;
        end
    end

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Scoreboard bench for gray_frame_ctrl: random/patterned frames, back-pressure, abort,
// ignored starts, error flag and mid-frame reset against a behavioural frame model.
module tb_gray_frame_ctrl;

    localparam int IMG_W = 28, IMG_H = 28, PX_BW = 32, GRAY_BW = 8, ADDR_BW = 10;
    localparam int N = IMG_W * IMG_H;

    logic clk = 1'b0, reset_n = 1'b0;
    logic i_start = 1'b0, i_abort = 1'b0, i_src_valid = 1'b0;
    logic [PX_BW-1:0] i_src_px = '0;
    logic o_src_ready, o_gf_valid, i_gf_valid, o_wr_en, o_busy, o_done, o_err;
    logic [PX_BW-1:0] o_gf_px;
    logic [GRAY_BW-1:0] i_gf_px, o_wr_data;
    logic [ADDR_BW-1:0] o_wr_addr;

    gray_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PX_BW(PX_BW),
                      .GRAY_BW(GRAY_BW), .ADDR_BW(ADDR_BW)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_src_px(i_src_px), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
        .o_gf_px(o_gf_px), .o_gf_valid(o_gf_valid), .i_gf_px(i_gf_px),
        .i_gf_valid(i_gf_valid), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gray(input logic [31:0] p);
        int r, g, b;
        r = int'(p[23:16]); g = int'(p[15:8]); b = int'(p[7:0]);
        return 8'((77 * r + 150 * g + 29 * b) >> 8);
    endfunction

    // one-cycle-latency gray filter; inject forces a stray result
    logic filt_valid, inject = 1'b0;
    logic [7:0] filt_px;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_valid <= 1'b0;
            filt_px    <= '0;
        end else begin
            filt_valid <= o_gf_valid;
            if (o_gf_valid) filt_px <= gray(o_gf_px);
        end
    end
    assign i_gf_valid = filt_valid | inject;
    assign i_gf_px    = filt_px;

    int checks = 0, errors = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    typedef struct { int hs_cyc; int addr; logic [7:0] data; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int wr_count, done_count, done_cyc;
    bit exp_err = 1'b0;

    always @(negedge clk) begin
        if (reset_n && o_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write cycle %0d got addr %0d expected no write",
                         cyc, o_wr_addr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", int'(o_wr_addr), mon_e.addr);
                chk("wr_data", int'(o_wr_data), int'(mon_e.data));
                chk("wr_latency", cyc, mon_e.hs_cyc + 3);
            end
        end
        if (reset_n && o_done) begin
            done_count++;
            done_cyc = cyc;
            chk("busy_at_done", int'(o_busy), 0);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, int'(o_src_ready), 0);
        chk({tag, "_gf_valid"}, int'(o_gf_valid), 0);
        chk({tag, "_gf_px"}, int'(o_gf_px), 0);
        chk({tag, "_wr_en"}, int'(o_wr_en), 0);
        chk({tag, "_wr_addr"}, int'(o_wr_addr), 0);
        chk({tag, "_wr_data"}, int'(o_wr_data), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_err"}, int'(o_err), 0);
    endtask

    function automatic logic [31:0] mkpx(input int pat, input int k);
        logic [7:0] kb;
        kb = 8'(k);
        return (pat == 0) ? {8'h00, kb, 8'h80, 8'h40} : $urandom;
    endfunction

    // vmode: 0 always valid, 1 toggle 1/0, 2 random valid
    task automatic run_frame(input int vmode, input int pat, input int abort_at,
                             input int start_in_stream, input bit start_in_done,
                             input bit reset_in_drain);
        int hs = 0, last_hs = -1, first_hs = -1, t0, abort_cyc = -1;
        bit tog = 1'b1, v, aborted = 1'b0, rst_done = 1'b0, ss_done = 1'b0;
        logic [31:0] px;
        wr_count = 0; done_count = 0; done_cyc = -1;
        px = mkpx(pat, 0);
        @(posedge clk); #1;
        i_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("start_err_clear", int'(o_err), 0);
        chk("start_ready", int'(o_src_ready), 1);
        chk("start_busy", int'(o_busy), 1);
        for (int budget = 0; budget < 4000; budget++) begin
            if (start_in_stream == hs && !ss_done) begin
                i_start = 1'b1;
                ss_done = 1'b1;
            end
            if (start_in_done && o_done) i_start = 1'b1;
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = !tog; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            i_src_valid = v;
            i_src_px    = px;
            if (v && o_src_ready) begin
                if (hs + 1 == abort_at) begin
                    i_abort   = 1'b1;
                    abort_cyc = cyc;
                    aborted   = 1'b1;
                    while (exp_q.size() > 0 && exp_q[$].hs_cyc > abort_cyc - 3)
                        void'(exp_q.pop_back());
                end else begin
                    exp_q.push_back('{hs_cyc: cyc, addr: hs, data: gray(px)});
                    if (hs == 0) first_hs = cyc;
                    hs++;
                    last_hs = cyc;
                    px = mkpx(pat, hs);
                end
            end
            @(posedge clk); #1;
            i_abort = 1'b0;
            i_start = 1'b0;
            if (aborted || done_count > 0) break;
            if (reset_in_drain && hs == N && cyc == last_hs + 2) begin
                chk("drain_busy", int'(o_busy), 1);
                chk("drain_ready", int'(o_src_ready), 0);
                reset_n = 1'b0;
                #1;
                chk_reset("rst_drain");
                exp_q.delete();
                @(posedge clk); @(posedge clk); #1;
                reset_n = 1'b1;
                rst_done = 1'b1;
                break;
            end
        end
        i_src_valid = 1'b0;
        if (vmode == 0 && !rst_done) chk("first_hs", first_hs, t0 + 1);
        if (aborted) begin
            chk("abort_busy", int'(o_busy), 0);
            chk("abort_gf_valid", int'(o_gf_valid), 0);
            exp_err = (last_hs == abort_cyc - 1);
            repeat (6) @(posedge clk);
            #1;
            chk("abort_no_done", done_count, 0);
            chk("abort_pending", exp_q.size(), 0);
            chk("abort_err", int'(o_err), int'(exp_err));
        end else if (rst_done) begin
            repeat (10) @(posedge clk);
            #1;
            exp_err = 1'b0;
            chk("rst_no_done", done_count, 0);
            chk("rst_busy", int'(o_busy), 0);
            chk("rst_ready", int'(o_src_ready), 0);
            chk("rst_err", int'(o_err), 0);
            chk("rst_pending", exp_q.size(), 0);
        end else begin
            repeat (5) @(posedge clk);
            #1;
            exp_err = 1'b0;
            chk("done_count", done_count, 1);
            chk("done_cycle", done_cyc, last_hs + 4);
            chk("write_count", wr_count, N);
            chk("pending", exp_q.size(), 0);
            chk("frame_err", int'(o_err), 0);
            chk("idle_busy", int'(o_busy), 0);
            chk("idle_ready", int'(o_src_ready), 0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk_reset("rst_rel");

        run_frame(0, 0, -1, -1, 1'b0, 1'b0);
        run_frame(1, 1, -1, -1, 1'b0, 1'b0);
        run_frame(0, 1, 400, -1, 1'b0, 1'b0);

        i_start = 1'b1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sa_busy", int'(o_busy), 0);
        chk("sa_ready", int'(o_src_ready), 0);
        chk("sa_err", int'(o_err), int'(exp_err));

        run_frame(2, 1, -1, -1, 1'b0, 1'b0);
        run_frame(2, 1, -1, 100, 1'b1, 1'b0);

        inject = 1'b1;
        @(posedge clk); #1;
        inject = 1'b0;
        chk("err_set", int'(o_err), 1);
        chk("err_no_wr", int'(o_wr_en), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", int'(o_err), 1);
        chk("err_idle", int'(o_busy), 0);

        run_frame(0, 1, -1, -1, 1'b0, 1'b0);
        run_frame(0, 1, -1, -1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle %0d got no end expected finish", cyc);
        $fatal(1);
    end

endmodule
